// File: rtl/taillight_seq.sv
// rtl/taillight_seq.sv - registered taillight LED sequencer for the LED bar
//
// Ports:
//   in_clock      - system clock, all state on rising edge
//   reset_n       - asynchronous active-low reset
//   current_state - light state: IDLE=0 HZRD=1 SIG_L=2 SIG_R=3 BRK=4
//                   BRK_SIG_L=5 BRK_SIG_R=6 (7 behaves as IDLE)
//   seq_mode      - 1 = sweep the turn side, 0 = flash the whole turn side
//   LEDR          - registered LED drive; left side at the top bits,
//                   right side at the bottom bits, unlit gap in between
module taillight_seq #(
  parameter int LEDS_PER_SIDE = 3,
  parameter int GAP           = 4,
  parameter int TICK_DIV      = 12_500_000,
  parameter int CENTER_BRAKE  = 0
) (
  input  logic                           in_clock,
  input  logic                           reset_n,
  input  logic [2:0]                     current_state,
  input  logic                           seq_mode,
  output logic [2*LEDS_PER_SIDE+GAP-1:0] LEDR
);

  localparam int N  = LEDS_PER_SIDE;
  localparam int W  = 2 * N + GAP;
  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = $clog2(N + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(N);

  localparam logic [2:0] ST_HZRD      = 3'd1;
  localparam logic [2:0] ST_SIG_L     = 3'd2;
  localparam logic [2:0] ST_SIG_R     = 3'd3;
  localparam logic [2:0] ST_BRK       = 3'd4;
  localparam logic [2:0] ST_BRK_SIG_L = 3'd5;
  localparam logic [2:0] ST_BRK_SIG_R = 3'd6;

  logic [2:0]    prev_state;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] step;
  logic          flash;
  logic          tick;
  logic          restart;

  logic [N-1:0]  left_turn;
  logic [N-1:0]  right_turn;
  logic [N-1:0]  left_side;
  logic [N-1:0]  right_side;
  logic          centre_on;
  logic [W-1:0]  next_led;

  assign tick    = (div_cnt == DIV_LAST);
  assign restart = (current_state != prev_state);

  // A state change restarts the sequence and wins over a coincident tick,
  // so the first step after a change is always held a full TICK_DIV cycles.
  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_state <= '0;
      div_cnt    <= '0;
      step       <= '0;
      flash      <= 1'b0;
      LEDR       <= '0;
    end else begin
      prev_state <= current_state;
      LEDR       <= next_led;
      if (restart) begin
        div_cnt <= '0;
        step    <= SW'(1);
        flash   <= 1'b1;
      end else if (tick) begin
        div_cnt <= '0;
        step    <= (step == STEP_LAST) ? '0 : step + 1'b1;
        flash   <= ~flash;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // The pattern is built from prev_state rather than current_state: on the
  // restart edge the counters still hold the old sequence, so decoding the
  // old state keeps the old pattern intact for that one edge and the new
  // state's pattern appears exactly when step/flash have been restarted.
  always_comb begin
    left_turn  = '0;
    right_turn = '0;
    left_side  = '0;
    right_side = '0;
    centre_on  = 1'b0;
    next_led   = '0;

    // Innermost LED of the left side is its lowest bit; of the right side,
    // its highest bit. Sweep lights the innermost `step` LEDs.
    for (int i = 0; i < N; i++) begin
      left_turn[i]  = seq_mode ? (i < int'(step))      : flash;
      right_turn[i] = seq_mode ? (i >= N - int'(step)) : flash;
    end

    case (prev_state)
      ST_HZRD: begin
        left_side  = {N{flash}};
        right_side = {N{flash}};
      end
      ST_SIG_L: left_side  = left_turn;
      ST_SIG_R: right_side = right_turn;
      ST_BRK: begin
        left_side  = '1;
        right_side = '1;
        centre_on  = (CENTER_BRAKE != 0);
      end
      ST_BRK_SIG_L: begin
        left_side  = left_turn;
        right_side = '1;
        centre_on  = (CENTER_BRAKE != 0);
      end
      ST_BRK_SIG_R: begin
        left_side  = '1;
        right_side = right_turn;
        centre_on  = (CENTER_BRAKE != 0);
      end
      default: ;
    endcase

    // Bit-wise assembly keeps GAP = 0 legal (no empty centre slice).
    for (int i = 0; i < W; i++) begin
      if (i < N) begin
        next_led[i] = right_side[i];
      end else if (i >= W - N) begin
        next_led[i] = left_side[i - (W - N)];
      end else begin
        next_led[i] = centre_on;
      end
    end
  end

endmodule

// File: tb/tb_taillight_seq.sv
// tb/tb_taillight_seq.sv - directed self-checking bench for taillight_seq
//
// Two instances share clock and reset: a 3/4/4 build with centre brake
// enabled, and a 5/2/3 build for the wide sweep.
module tb_taillight_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  st;
  logic [2:0]  st_w;
  logic        mode;
  logic [9:0]  led;
  logic [11:0] led_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  taillight_seq #(
    .LEDS_PER_SIDE(3), .GAP(4), .TICK_DIV(4), .CENTER_BRAKE(1)
  ) dut (
    .in_clock(clk), .reset_n(rst_n), .current_state(st),
    .seq_mode(mode), .LEDR(led)
  );

  taillight_seq #(
    .LEDS_PER_SIDE(5), .GAP(2), .TICK_DIV(3), .CENTER_BRAKE(0)
  ) dut_w (
    .in_clock(clk), .reset_n(rst_n), .current_state(st_w),
    .seq_mode(mode), .LEDR(led_w)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic hold(input string tag, input logic [9:0] exp, input int n);
    repeat (n) begin
      @(negedge clk);
      check(tag, 32'(led), 32'(exp));
    end
  endtask

  task automatic hold_w(input string tag, input logic [11:0] exp, input int n);
    repeat (n) begin
      @(negedge clk);
      check(tag, 32'(led_w), 32'(exp));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st    = 3'd0;
    st_w  = 3'd0;
    mode  = 1'b1;
    #1;
    check("reset_led", 32'(led), 32'd0);
    check("reset_led_w", 32'(led_w), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold("idle", 10'b0, 3);

    // Left sweep
    st = 3'd2;
    mode = 1'b1;
    @(negedge clk);
    check("sigl_pre", 32'(led), 32'd0);
    hold("sigl_s1", 10'b0010000000, 4);
    hold("sigl_s2", 10'b0110000000, 4);
    hold("sigl_s3", 10'b1110000000, 4);
    hold("sigl_s0", 10'b0000000000, 4);
    hold("sigl_s1b", 10'b0010000000, 4);

    // Brake + right flash with centre brake
    st = 3'd6;
    mode = 1'b0;
    @(negedge clk);
    hold("bsr_on", 10'b1111111111, 4);
    hold("bsr_off", 10'b1111111000, 4);
    hold("bsr_on2", 10'b1111111111, 4);

    // Hazard ignores seq_mode
    st = 3'd1;
    mode = 1'b1;
    @(negedge clk);
    hold("hz_on", 10'b1110000111, 4);
    hold("hz_off", 10'b0000000000, 4);
    hold("hz_on2", 10'b1110000111, 4);

    // Restart: SIG_R to step 3, one cycle of SIG_L, back to SIG_R
    st = 3'd3;
    @(negedge clk);
    hold("sigr_s1", 10'b0000000100, 4);
    hold("sigr_s2", 10'b0000000110, 4);
    hold("sigr_s3", 10'b0000000111, 1);
    st = 3'd2;
    hold("rs_keep", 10'b0000000111, 1);
    st = 3'd3;
    hold("rs_sigl", 10'b0010000000, 1);
    hold("rs_sigr1", 10'b0000000100, 4);
    hold("rs_sigr2", 10'b0000000110, 1);

    // Wide build: right sweep through LEDR[4:0]
    st_w = 3'd3;
    @(negedge clk);
    check("w_pre", 32'(led_w), 32'd0);
    hold_w("w_s1", 12'b000000010000, 3);
    hold_w("w_s2", 12'b000000011000, 3);
    hold_w("w_s3", 12'b000000011100, 3);
    hold_w("w_s4", 12'b000000011110, 3);
    hold_w("w_s5", 12'b000000011111, 3);
    hold_w("w_s0", 12'b000000000000, 3);
    hold_w("w_s1b", 12'b000000010000, 3);

    // Mid-sequence async reset clears outputs within the cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", 32'(led), 32'd0);
    check("mid_reset_w", 32'(led_w), 32'd0);
    st = 3'd0;
    st_w = 3'd0;
    @(negedge clk);
    check("in_reset", 32'(led), 32'd0);
    rst_n = 1'b1;
    hold("post_idle", 10'b0, 4);
    hold_w("post_idle_w", 12'b0, 2);

    // Steady brake with centre brake lit
    st = 3'd4;
    @(negedge clk);
    hold("brk", 10'b1111111111, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
